// File: rtl/rx_4phase_buf_pkg.sv
// rtl/rx_4phase_buf_pkg.sv - shared word width, FIFO sizing and handshake state encodings
package rx_4phase_buf_pkg;
  localparam int DATA_MSB = 7;
  localparam int DEPTH    = 4;
  localparam int PTR_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hs_state_t;
endpackage

// File: rtl/rx_4phase_buf_if.sv
// rtl/rx_4phase_buf_if.sv - four-phase receive handshake plus consumer pop bundle
interface rx_4phase_buf_if
  #(parameter int DATA_MSB = rx_4phase_buf_pkg::DATA_MSB);
  logic              req;
  logic [DATA_MSB:0] input_rx;
  logic              ack;
  logic [DATA_MSB:0] output_rx;
  logic              d;
  logic              f;
  logic              rd;

  modport master (output req, input_rx, rd, input ack, output_rx, d, f);
  modport slave  (input req, input_rx, rd, output ack, output_rx, d, f);
endinterface

// File: rtl/rx_4phase_buf_sync2.sv
// rtl/rx_4phase_buf_sync2.sv - generic two-flop synchroniser with async active-high reset
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);
  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      q_out <= 1'b0;
    end else begin
      s1    <= d_in;
      q_out <= s1;
    end
  end
endmodule

// File: rtl/rx_4phase_buf.sv
// rtl/rx_4phase_buf.sv - four-phase CDC receiver capturing words into a small FIFO
module rx_4phase_buf
  import rx_4phase_buf_pkg::*;
#(
  parameter int DATA_MSB = rx_4phase_buf_pkg::DATA_MSB,
  parameter int DEPTH    = rx_4phase_buf_pkg::DEPTH,
  parameter int PTR_W    = rx_4phase_buf_pkg::PTR_W
) (
  input logic            clk,
  input logic            reset,
  rx_4phase_buf_if.slave bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic              req_s2;
  hs_state_t         state, state_next;
  logic [DATA_MSB:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_next;
  logic              d_r, f_r, wr_en, rd_en;

  sync2 u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (bus.req),
    .q_out (req_s2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A full FIFO holds the FSM in IDLE with ack low, back-pressuring the transmitter.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    case (state)
      ST_IDLE: if (req_s2 && !f_r) begin
        wr_en      = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: if (!req_s2) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_en = bus.rd && d_r;

  always_comb begin
    case ({wr_en, rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      d_r    <= 1'b0;
      f_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= bus.input_rx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      d_r   <= (count_next != '0);
      f_r   <= (count_next == FULL_CNT);
    end
  end

  assign bus.ack       = (state == ST_HOLD);
  assign bus.d         = d_r;
  assign bus.f         = f_r;
  assign bus.output_rx = mem[rd_ptr];
endmodule

// File: tb/tb_rx_4phase_buf.sv
// tb/tb_rx_4phase_buf.sv - self-checking bench for rx_4phase_buf
module tb_rx_4phase_buf;
  typedef struct {
    logic [7:0] data;
    logic       exp_d;
    logic       exp_f;
  } fill_vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  fill_vec_t  fv [4];
  int         n;

  rx_4phase_buf_if #(.DATA_MSB(7)) bus ();

  rx_4phase_buf #(.DATA_MSB(7), .DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lvl(input logic lvl, input int max, output int cnt);
    cnt = 0;
    while (bus.ack !== lvl && cnt < max) begin
      step();
      cnt++;
    end
  endtask

  task automatic handshake(input logic [7:0] w, input string name);
    int c;
    bus.input_rx = w;
    bus.req = 1'b1;
    wait_lvl(1'b1, 40, c);
    check({name, "_rise_lat"}, 32'(c), 32'd3);
    sb.push_back(w);
    bus.req = 1'b0;
    wait_lvl(1'b0, 40, c);
    check({name, "_fall_lat"}, 32'(c), 32'd3);
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    bus.rd = 1'b1;
    while (bus.d && c < 20) begin
      step();
      c++;
    end
    bus.rd = 1'b0;
    check({name, "_empty"}, 32'(bus.d), 32'd0);
  endtask

  // Each pop is scored against the oldest word the bench handed over.
  always @(negedge clk) begin
    if (!reset && bus.rd && bus.d) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no pop", bus.output_rx);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("pop_order", 32'(bus.output_rx), 32'(e));
      end
    end
  end

  initial begin
    fv[0] = '{8'h01, 1'b1, 1'b0};
    fv[1] = '{8'h02, 1'b1, 1'b0};
    fv[2] = '{8'h03, 1'b1, 1'b0};
    fv[3] = '{8'h04, 1'b1, 1'b1};

    bus.req = 1'b0;
    bus.input_rx = '0;
    bus.rd = 1'b0;
    repeat (3) step();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_d", 32'(bus.d), 32'd0);
    check("rst_f", 32'(bus.f), 32'd0);
    check("rst_out", 32'(bus.output_rx), 32'd0);
    reset = 1'b0;
    step();

    bus.input_rx = 8'hA5;
    bus.req = 1'b1;
    step();
    step();
    check("single_ack_e2", 32'(bus.ack), 32'd0);
    check("single_d_e2", 32'(bus.d), 32'd0);
    step();
    check("single_ack_e3", 32'(bus.ack), 32'd1);
    check("single_d_e3", 32'(bus.d), 32'd1);
    check("single_out_e3", 32'(bus.output_rx), 32'hA5);
    sb.push_back(8'hA5);
    bus.req = 1'b0;
    step();
    step();
    check("single_ackfall_e2", 32'(bus.ack), 32'd1);
    step();
    check("single_ackfall_e3", 32'(bus.ack), 32'd0);
    drain("single");

    for (int i = 0; i < 4; i++) begin
      handshake(fv[i].data, "fill");
      check("fill_d", 32'(bus.d), 32'(fv[i].exp_d));
      check("fill_f", 32'(bus.f), 32'(fv[i].exp_f));
    end

    bus.input_rx = 8'h05;
    bus.req = 1'b1;
    repeat (10) step();
    check("stall_ack", 32'(bus.ack), 32'd0);
    check("stall_head", 32'(bus.output_rx), 32'h01);
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    check("stall_f_after_pop", 32'(bus.f), 32'd0);
    check("stall_ack_pop_edge", 32'(bus.ack), 32'd0);
    step();
    check("stall_ack_next_edge", 32'(bus.ack), 32'd1);
    sb.push_back(8'h05);
    bus.req = 1'b0;
    wait_lvl(1'b0, 40, n);
    check("stall_fall_lat", 32'(n), 32'd3);
    drain("stall");

    bus.rd = 1'b1;
    for (int i = 0; i < 10; i++) handshake(8'(8'h10 + i), "stream");
    step();
    step();
    bus.rd = 1'b0;
    check("stream_sb_empty", 32'(sb.size()), 32'd0);
    check("stream_d", 32'(bus.d), 32'd0);

    handshake(8'h20, "simul");
    handshake(8'h21, "simul");
    bus.input_rx = 8'h22;
    bus.req = 1'b1;
    step();
    step();
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    sb.push_back(8'h22);
    check("simul_ack", 32'(bus.ack), 32'd1);
    check("simul_d", 32'(bus.d), 32'd1);
    check("simul_f", 32'(bus.f), 32'd0);
    check("simul_head", 32'(bus.output_rx), 32'h21);
    check("simul_count", 32'(dut.count), 32'd2);
    bus.req = 1'b0;
    wait_lvl(1'b0, 40, n);
    drain("simul");

    handshake(8'h30, "rstmid");
    handshake(8'h31, "rstmid");
    bus.input_rx = 8'h32;
    bus.req = 1'b1;
    wait_lvl(1'b1, 40, n);
    check("rstmid_rise_lat", 32'(n), 32'd3);
    check("rstmid_count", 32'(dut.count), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("rstmid_ack", 32'(bus.ack), 32'd0);
    check("rstmid_d", 32'(bus.d), 32'd0);
    check("rstmid_f", 32'(bus.f), 32'd0);
    check("rstmid_out", 32'(bus.output_rx), 32'd0);
    sb.delete();
    step();
    reset = 1'b0;
    wait_lvl(1'b1, 40, n);
    check("rstmid_new_lat", 32'(n), 32'd3);
    check("rstmid_new_out", 32'(bus.output_rx), 32'h32);
    sb.push_back(8'h32);
    repeat (5) step();
    check("rstmid_one_capture", 32'(dut.count), 32'd1);
    bus.req = 1'b0;
    wait_lvl(1'b0, 40, n);
    drain("rstmid");

    bus.rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("emptypop_d", 32'(bus.d), 32'd0);
      check("emptypop_out", 32'(bus.output_rx), 32'd0);
      check("emptypop_rdptr", 32'(dut.rd_ptr), 32'd1);
    end
    bus.rd = 1'b0;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
